// File: rtl/s1_fetch.sv
// Stage-1 fetch: owns the PC, drives the BIOS/IMEM read ports and registers
// the fetched instruction and its PC into the s1/s2 boundary.
module s1_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [11:0] bios_addr,
  input  logic [31:0] bios_dout,
  output logic [13:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] instruction_s2,
  output logic [31:0] pc_s2,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h4000_0000;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;
  localparam logic [3:0]      BIOS_SEG = 4'b0100;

  logic [XLEN-1:0] pc_f;
  logic            valid_f;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] fetch_instr;

  assign target = redirect_target & ~XLEN'(3);

  // Address for the next cycle; reset forces the BIOS base so the first fetch
  // is already in flight when reset releases.
  always_comb begin
    next_pc = pc_f + XLEN'(4);
    if (rst) begin
      next_pc = RESET_PC;
    end else if (redirect) begin
      next_pc = target;
    end else if (stall) begin
      next_pc = pc_f;
    end
  end

  assign bios_addr   = next_pc[13:2];
  assign imem_addr   = next_pc[15:2];
  assign fetch_instr = (pc_f[31:28] == BIOS_SEG) ? bios_dout : imem_dout;

  // Redirect beats stall; a redirected slot becomes a bubble and is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f           <= RESET_PC - XLEN'(4);
      valid_f        <= 1'b0;
      instruction_s2 <= NOP;
      pc_s2          <= '0;
      fetch_count    <= '0;
    end else if (redirect) begin
      instruction_s2 <= NOP;
      pc_s2          <= pc_f;
      pc_f           <= next_pc;
      valid_f        <= 1'b1;
    end else if (!stall) begin
      instruction_s2 <= valid_f ? fetch_instr : NOP;
      pc_s2          <= pc_f;
      pc_f           <= next_pc;
      valid_f        <= 1'b1;
      fetch_count    <= fetch_count + XLEN'(valid_f);
    end
  end

endmodule
